osc_param_loader: RTL and testbench

Parameter front-end for the 64-channel oscillator summing tree. Receives 3-byte command frames over a valid/ready byte stream, builds per-channel amplitude, offset and phase-word values in a shadow bank, and copies the whole bank to the live 1024-bit buses in one cycle on a commit command. The live buses drive the amps/offsets/phasewords inputs of the 64-channel block directly, so all channels change together and no mixed old/new parameter set reaches the oscillators.

---
 rtl/osc_param_loader.sv | 198 +++++++++++++++++++
 tb/tb_osc_param_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_param_loader.sv
// osc_param_loader
// Parameter front-end for the 64-channel oscillator summing tree. Collects
// 3-byte command frames (CMD, DATA_HI, DATA_LO) from a valid/ready byte stream
// into a shadow bank. A commit command copies the whole bank to the live
// buses in a single edge, so the oscillators never see a mixed parameter set.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   in_data      frame byte
//   in_valid     in_data valid
//   in_ready     loader accepts a byte this cycle (low only during COMMIT)
//   amps         live amplitudes,   channel n at [16n+15:16n]
//   offsets      live offsets,      same packing
//   phasewords   live phase words,  same packing
//   commit_done  one-cycle pulse, first cycle new live values are visible
//   frame_err    one-cycle pulse when a partial frame is dropped on timeout
module osc_param_loader #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [1023:0] amps,
  output logic [1023:0] offsets,
  output logic [1023:0] phasewords,
  output logic          commit_done,
  output logic          frame_err
);

  localparam int unsigned FW = 16;
  localparam int unsigned BW = 1024;
  localparam int unsigned GW = 16;
  localparam int unsigned IW = 10;

  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

  localparam logic [1:0] OP_AMP  = 2'b00;
  localparam logic [1:0] OP_OFF  = 2'b01;
  localparam logic [1:0] OP_PH   = 2'b10;
  localparam logic [1:0] OP_CTRL = 2'b11;

  localparam logic [5:0] CTRL_COMMIT = 6'd0;
  localparam logic [5:0] CTRL_CLEAR  = 6'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_COMMIT
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      hi_q, hi_d;
  logic [BW-1:0]   sh_amp_q, sh_amp_d;
  logic [BW-1:0]   sh_off_q, sh_off_d;
  logic [BW-1:0]   sh_ph_q, sh_ph_d;
  logic [BW-1:0]   live_amp_q, live_amp_d;
  logic [BW-1:0]   live_off_q, live_off_d;
  logic [BW-1:0]   live_ph_q, live_ph_d;
  logic            in_ready_q, in_ready_d;
  logic            commit_done_q, commit_done_d;
  logic            frame_err_q, frame_err_d;

  logic            accept;
  logic [1:0]      op;
  logic [5:0]      ch;
  logic [IW-1:0]   widx;
  logic [FW-1:0]   wval;

  // Next-state, shadow/live bank updates and output pulses
  always_comb begin
    state_d       = state_q;
    gap_d         = '0;
    cmd_d         = cmd_q;
    hi_d          = hi_q;
    sh_amp_d      = sh_amp_q;
    sh_off_d      = sh_off_q;
    sh_ph_d       = sh_ph_q;
    live_amp_d    = live_amp_q;
    live_off_d    = live_off_q;
    live_ph_d     = live_ph_q;
    commit_done_d = 1'b0;
    frame_err_d   = 1'b0;

    accept = in_valid && in_ready_q;
    op     = cmd_q[7:6];
    ch     = cmd_q[5:0];
    widx   = {ch, 4'b0000};
    wval   = {hi_q, in_data};

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d   = in_data;
          state_d = S_HI;
        end
      end

      S_HI: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = S_LO;
        end else if (gap_q == GAP_LAST) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      S_LO: begin
        if (accept) begin
          state_d = S_IDLE;
          unique case (op)
            OP_AMP:  sh_amp_d[widx +: FW] = wval;
            OP_OFF:  sh_off_d[widx +: FW] = wval;
            OP_PH:   sh_ph_d[widx +: FW]  = wval;
            OP_CTRL: begin
              if (ch == CTRL_COMMIT) begin
                state_d = S_COMMIT;
              end else if (ch == CTRL_CLEAR) begin
                sh_amp_d = '0;
                sh_off_d = '0;
                sh_ph_d  = '0;
              end
            end
            default: ;
          endcase
        end else if (gap_q == GAP_LAST) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      S_COMMIT: begin
        // Whole bank moves in one edge; commit_done lines up with new values
        live_amp_d    = sh_amp_q;
        live_off_d    = sh_off_q;
        live_ph_d     = sh_ph_q;
        commit_done_d = 1'b1;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Registered ready tracks the state we are about to enter
    in_ready_d = (state_d != S_COMMIT);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      gap_q         <= '0;
      cmd_q         <= '0;
      hi_q          <= '0;
      sh_amp_q      <= '0;
      sh_off_q      <= '0;
      sh_ph_q       <= '0;
      live_amp_q    <= '0;
      live_off_q    <= '0;
      live_ph_q     <= '0;
      in_ready_q    <= 1'b1;
      commit_done_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      cmd_q         <= cmd_d;
      hi_q          <= hi_d;
      sh_amp_q      <= sh_amp_d;
      sh_off_q      <= sh_off_d;
      sh_ph_q       <= sh_ph_d;
      live_amp_q    <= live_amp_d;
      live_off_q    <= live_off_d;
      live_ph_q     <= live_ph_d;
      in_ready_q    <= in_ready_d;
      commit_done_q <= commit_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign amps        = live_amp_q;
  assign offsets     = live_off_q;
  assign phasewords  = live_ph_q;
  assign commit_done = commit_done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_osc_param_loader.sv
// Self-checking bench for osc_param_loader: directed frame vectors with
// hand-computed expected fields, plus hand-written timeout, clear and
// reset-during-commit sequences. A small shadow/live model tracks whole buses.
module tb_osc_param_loader;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1023:0] amps;
  logic [1023:0] offsets;
  logic [1023:0] phasewords;
  logic          commit_done;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int fe_count = 0;
  int cd_count = 0;

  logic [1023:0] sa = '0, so = '0, sp = '0;
  logic [1023:0] la = '0, lo = '0, lp = '0;

  osc_param_loader #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .amps        (amps),
    .offsets     (offsets),
    .phasewords  (phasewords),
    .commit_done (commit_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sample pre-edge values at the rising edge
  always @(posedge clk) begin
    if (frame_err) fe_count++;
    if (commit_done) cd_count++;
  end

  always @(negedge clk) begin
    if (reset && commit_done && frame_err) begin
      errors++;
      $display("FAIL pulse_overlap: commit_done=%0b frame_err=%0b required not both 1", commit_done, frame_err);
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [1:0]  fld;
    int          ch;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chkbus(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int c = 0; c < 64; c++) begin
        if (act[c*16 +: 16] !== exp[c*16 +: 16]) begin
          $display("FAIL %s: channel %0d got %h required %h", name, c, act[c*16 +: 16], exp[c*16 +: 16]);
          break;
        end
      end
    end
  endtask

  function automatic logic [15:0] fld(input logic [1023:0] bus, input int ch);
    return bus[ch*16 +: 16];
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rise
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL send_byte_wait: in_ready stayed %0b required 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] hi, input logic [7:0] lo_b);
    int c;
    send_byte(cmd);
    send_byte(hi);
    send_byte(lo_b);
    c = int'(cmd[5:0]);
    case (cmd[7:6])
      2'b00: sa[c*16 +: 16] = {hi, lo_b};
      2'b01: so[c*16 +: 16] = {hi, lo_b};
      2'b10: sp[c*16 +: 16] = {hi, lo_b};
      default: if (cmd[5:0] == 6'd1) begin sa = '0; so = '0; sp = '0; end
    endcase
  endtask

  task automatic do_commit(input string tag);
    send_frame(8'hC0, 8'h00, 8'h00);
    chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    chk({tag, "_done_early"}, 32'(commit_done), 32'd0);
    chkbus({tag, "_amps_old"}, amps, la);
    la = sa; lo = so; lp = sp;
    @(negedge clk);
    chk({tag, "_done"}, 32'(commit_done), 32'd1);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    chkbus({tag, "_amps"}, amps, la);
    chkbus({tag, "_offsets"}, offsets, lo);
    chkbus({tag, "_phasewords"}, phasewords, lp);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(commit_done), 32'd0);
  endtask

  initial begin
    int fe0;
    int cd0;
    logic [15:0] act;

    vecs[0] = '{cmd: 8'hBF, hi: 8'hFF, lo: 8'hFF, fld: 2'd2, ch: 63, exp: 16'hFFFF};
    vecs[1] = '{cmd: 8'h40, hi: 8'h80, lo: 8'h00, fld: 2'd1, ch: 0,  exp: 16'h8000};
    vecs[2] = '{cmd: 8'h00, hi: 8'hFF, lo: 8'hFE, fld: 2'd0, ch: 0,  exp: 16'hFFFE};
    vecs[3] = '{cmd: 8'h05, hi: 8'hAB, lo: 8'hCD, fld: 2'd0, ch: 5,  exp: 16'hABCD};
    vecs[4] = '{cmd: 8'h7F, hi: 8'h00, lo: 8'h01, fld: 2'd1, ch: 63, exp: 16'h0001};
    vecs[5] = '{cmd: 8'h9F, hi: 8'h5A, lo: 8'hA5, fld: 2'd2, ch: 31, exp: 16'h5AA5};

    // Reset
    #2 reset = 1'b0;
    #1;
    chkbus("rst_amps", amps, '0);
    chkbus("rst_offsets", offsets, '0);
    chkbus("rst_phasewords", phasewords, '0);
    chk("rst_done", 32'(commit_done), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      chk("post_rst_pulses", 32'({commit_done, frame_err}), 32'd0);
    end
    chkbus("post_rst_amps", amps, '0);
    chkbus("post_rst_phasewords", phasewords, '0);

    // Amp ch5 held in shadow until commit
    send_frame(8'h05, 8'h12, 8'h34);
    repeat (2) @(negedge clk);
    chkbus("shadow_hidden", amps, '0);
    do_commit("c1");
    chk("amp_ch5", 32'(fld(amps, 5)), 32'h1234);
    chk("amp_ch4", 32'(fld(amps, 4)), 32'h0000);

    // Table of single-field writes, each followed by a commit
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].cmd, vecs[i].hi, vecs[i].lo);
      do_commit($sformatf("vec%0d", i));
      case (vecs[i].fld)
        2'd0:    act = fld(amps, vecs[i].ch);
        2'd1:    act = fld(offsets, vecs[i].ch);
        default: act = fld(phasewords, vecs[i].ch);
      endcase
      chk($sformatf("vec%0d_field", i), 32'(act), 32'(vecs[i].exp));
    end
    chk("ph63_pack", 32'(phasewords[1023:1008]), 32'hFFFF);
    chk("off0_pack", 32'(offsets[15:0]), 32'h8000);

    // Last write wins
    send_frame(8'h02, 8'h11, 8'h11);
    send_frame(8'h02, 8'h22, 8'h22);
    do_commit("lww");
    chk("lww_amp_ch2", 32'(fld(amps, 2)), 32'h2222);

    // Timeout drops partial frame
    fe0 = fe_count;
    send_byte(8'h41);
    send_byte(8'hAA);
    repeat (7) @(negedge clk);
    chk("to_no_early_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    chk("to_err_pulse", 32'(frame_err), 32'd1);
    chk("to_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("to_err_one_cycle", 32'(frame_err), 32'd0);
    repeat (4) @(negedge clk);
    chk("to_err_count", 32'(fe_count - fe0), 32'd1);
    send_frame(8'h41, 8'h00, 8'h07);
    do_commit("to");
    chk("to_off_ch1", 32'(fld(offsets, 1)), 32'h0007);

    // Byte on the would-expire cycle wins
    fe0 = fe_count;
    send_byte(8'h42);
    send_byte(8'h11);
    repeat (7) @(negedge clk);
    send_byte(8'h22);
    so[2*16 +: 16] = 16'h1122;
    repeat (3) @(negedge clk);
    chk("edge_no_err", 32'(fe_count - fe0), 32'd0);
    do_commit("edge");
    chk("edge_off_ch2", 32'(fld(offsets, 2)), 32'h1122);

    // Clear shadow then commit zeroes every live channel
    send_frame(8'hC1, 8'hAA, 8'h55);
    chkbus("clr_live_kept", offsets, lo);
    chk("clr_live_ch5", 32'(fld(amps, 5)), 32'hABCD);
    do_commit("clr");
    chkbus("clr_amps_zero", amps, '0);
    chkbus("clr_offsets_zero", offsets, '0);
    chkbus("clr_ph_zero", phasewords, '0);

    // Reset while in COMMIT
    send_frame(8'h03, 8'h33, 8'h33);
    do_commit("pre_rst");
    chk("pre_rst_amp_ch3", 32'(fld(amps, 3)), 32'h3333);
    send_frame(8'h07, 8'h07, 8'h77);
    cd0 = cd_count;
    send_frame(8'hC0, 8'h00, 8'h00);
    chk("rc_in_commit", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chkbus("rc_amps_zero", amps, '0);
    chk("rc_done", 32'(commit_done), 32'd0);
    sa = '0; so = '0; sp = '0; la = '0; lo = '0; lp = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rc_no_commit_done", 32'(cd_count - cd0), 32'd0);
    chkbus("rc_amps_after", amps, '0);
    do_commit("rc_post");
    chk("rc_amp_ch7", 32'(fld(amps, 7)), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded bound", $time);
    $fatal(1, "global timeout");
  end

endmodule
